// File: rtl/audio_pkg.sv
// Shared types and constants for the HDMI audio sample pacer.
package audio_pkg;

    typedef enum logic {
        UR_HOLD = 1'b0,
        UR_ZERO = 1'b1
    } underrun_mode_t;

    localparam logic [8:0] VOLUME_UNITY = 9'd256;
    localparam int         UNDERRUN_W   = 16;

    function automatic logic [8:0] clamp_volume(input logic [8:0] v);
        return (v > VOLUME_UNITY) ? VOLUME_UNITY : v;
    endfunction

endpackage

// File: rtl/audio_phase_acc.sv
// Fractional phase accumulator: emits SAMPLE_RATE ticks per CLK_HZ cycles on
// average, plus a roughly 50% duty registered clock that falls at each tick.
module audio_phase_acc #(
    parameter int CLK_HZ      = 75_000_000,
    parameter int SAMPLE_RATE = 48_000
) (
    input  logic clk_pixel,
    input  logic reset_n,
    input  logic enable,
    output logic tick_comb,
    output logic tick,
    output logic clk_out
);

    localparam int AW = $clog2(CLK_HZ) + 1;
    localparam logic [AW-1:0] CLK_K  = AW'(CLK_HZ);
    localparam logic [AW-1:0] HALF_K = AW'(CLK_HZ / 2);
    localparam logic [AW-1:0] STEP_K = AW'(SAMPLE_RATE);

    generate
        if (SAMPLE_RATE <= 0 || SAMPLE_RATE >= CLK_HZ / 4) begin : g_rate_check
            $error("audio_phase_acc: SAMPLE_RATE must be positive and below CLK_HZ/4");
        end
    endgenerate

    logic [AW-1:0] acc_q, acc_d, nxt;
    logic          tick_q, clk_q;

    // acc < CLK_HZ and step < CLK_HZ/4, so the sum never overflows AW bits.
    always_comb begin
        nxt       = acc_q + STEP_K;
        tick_comb = enable && (nxt >= CLK_K);
        acc_d     = nxt;
        if (!enable) begin
            acc_d = '0;
        end else if (tick_comb) begin
            acc_d = nxt - CLK_K;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_comb;
            clk_q  <= (acc_d >= HALF_K);
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_q;

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces multi-channel audio frames out of a show-ahead FIFO at an exact
// average sample rate, applies volume, and handles FIFO underrun.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int             CLK_HZ        = 75_000_000,
    parameter int             SAMPLE_RATE   = 48_000,
    parameter int             CHANNELS      = 2,
    parameter int             SAMPLE_WIDTH  = 16,
    parameter underrun_mode_t UNDERRUN_MODE = UR_HOLD
) (
    input  logic                                     clk_pixel,
    input  logic                                     reset_n,
    input  logic                                     enable,
    input  logic [8:0]                               volume,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]         fifo_data,
    input  logic                                     fifo_empty,
    output logic                                     fifo_rden,
    output logic                                     sample_strobe,
    output logic                                     clk_audio,
    output logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0]    audio_sample_word,
    input  logic                                     underrun_clear,
    output logic [UNDERRUN_W-1:0]                    underrun_count
);

    generate
        if (CHANNELS < 1) begin : g_chan_check
            $error("audio_sample_pacer: CHANNELS must be at least 1");
        end
    endgenerate

    // Gain never exceeds unity, so truncating the shifted product is safe.
    function automatic logic [SAMPLE_WIDTH-1:0] scale(
        input logic signed [SAMPLE_WIDTH-1:0] s,
        input logic [8:0]                     v
    );
        logic signed [SAMPLE_WIDTH+9:0] prod;
        prod = s * $signed({1'b0, v});
        return SAMPLE_WIDTH'(prod >>> 8);
    endfunction

    logic                                  tick_comb;
    logic [CHANNELS*SAMPLE_WIDTH-1:0]      s1_q, s1_d;
    logic                                  s1_vld_q;
    logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0] word_q, word_d, scaled;
    logic [UNDERRUN_W-1:0]                 ur_cnt_q, ur_cnt_d;
    logic [8:0]                            vol_c;

    audio_phase_acc #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_phase (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .enable    (enable),
        .tick_comb (tick_comb),
        .tick      (sample_strobe),
        .clk_out   (clk_audio)
    );

    assign fifo_rden = tick_comb && !fifo_empty;
    assign vol_c     = clamp_volume(volume);

    // Stage 1: pop the FIFO head, or apply the underrun policy when empty.
    always_comb begin
        s1_d     = s1_q;
        ur_cnt_d = ur_cnt_q;
        if (tick_comb) begin
            if (!fifo_empty) begin
                s1_d = fifo_data;
            end else if (UNDERRUN_MODE == UR_ZERO) begin
                s1_d = '0;
            end
        end
        if (underrun_clear) begin
            ur_cnt_d = '0;
        end else if (tick_comb && fifo_empty && (ur_cnt_q != '1)) begin
            ur_cnt_d = ur_cnt_q + UNDERRUN_W'(1);
        end
    end

    // Stage 2: per-channel volume scaling, volume sampled in this cycle.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign scaled[c] = scale(s1_q[c*SAMPLE_WIDTH +: SAMPLE_WIDTH], vol_c);
    end

    always_comb begin
        word_d = s1_vld_q ? scaled : word_q;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            word_q   <= '0;
            ur_cnt_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s1_vld_q <= tick_comb;
            word_q   <= word_d;
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign audio_sample_word = word_q;
    assign underrun_count    = ur_cnt_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer at CLK_HZ=100, SAMPLE_RATE=8, with a
// hold-mode and a zero-mode instance sharing the same stimulus.
module tb_audio_sample_pacer;
    import audio_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [8:0]  vol;
    logic [31:0] fdata;
    logic        fempty;
    logic        uclr;

    logic              rden_h, strobe_h, clk_h;
    logic [1:0][15:0]  word_h;
    logic [15:0]       cnt_h;
    logic              rden_z, strobe_z, clk_z;
    logic [1:0][15:0]  word_z;
    logic [15:0]       cnt_z;

    int n_cmp = 0;
    int n_err = 0;

    audio_sample_pacer #(
        .CLK_HZ(100), .SAMPLE_RATE(8), .CHANNELS(2), .SAMPLE_WIDTH(16),
        .UNDERRUN_MODE(UR_HOLD)
    ) dut_h (
        .clk_pixel(clk), .reset_n(rst_n), .enable(en), .volume(vol),
        .fifo_data(fdata), .fifo_empty(fempty), .fifo_rden(rden_h),
        .sample_strobe(strobe_h), .clk_audio(clk_h),
        .audio_sample_word(word_h), .underrun_clear(uclr),
        .underrun_count(cnt_h)
    );

    audio_sample_pacer #(
        .CLK_HZ(100), .SAMPLE_RATE(8), .CHANNELS(2), .SAMPLE_WIDTH(16),
        .UNDERRUN_MODE(UR_ZERO)
    ) dut_z (
        .clk_pixel(clk), .reset_n(rst_n), .enable(en), .volume(vol),
        .fifo_data(fdata), .fifo_empty(fempty), .fifo_rden(rden_z),
        .sample_strobe(strobe_z), .clk_audio(clk_z),
        .audio_sample_word(word_z), .underrun_clear(uclr),
        .underrun_count(cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        uclr  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rden(input string name);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (rden_h === 1'b1) ok = 1;
            else tick();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: fifo_rden not seen within 40 cycles", name);
        end
    endtask

    task automatic wait_strobe(input string name, inout bit rd_seen);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (rden_h === 1'b1 || rden_z === 1'b1) rd_seen = 1;
            if (strobe_h === 1'b1) ok = 1;
            else tick();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: sample_strobe not seen within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        vol    = 9'd256;
        fdata  = 32'hABCD_1234;
        fempty = 1'b0;
        uclr   = 1'b0;
        #3;
        n_cmp++;
        if ({rden_h, strobe_h, clk_h} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl_h: got %b expected 000", {rden_h, strobe_h, clk_h});
        end
        n_cmp++;
        if ({rden_z, strobe_z, clk_z} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl_z: got %b expected 000", {rden_z, strobe_z, clk_z});
        end
        n_cmp++;
        if (word_h !== 32'h0 || word_z !== 32'h0) begin
            n_err++;
            $display("FAIL reset_word: got %h/%h expected 0", word_h, word_z);
        end
        n_cmp++;
        if (cnt_h !== 16'h0 || cnt_z !== 16'h0) begin
            n_err++;
            $display("FAIL reset_count: got %h/%h expected 0", cnt_h, cnt_z);
        end
    endtask

    task automatic test_rate();
        int nr = 0, ns = 0, last = -1, badsp = 0, badal = 0, badclk = 0, hi = 0;
        int nq = 0, first = 0;
        logic prev_r = 1'b0;
        do_reset();
        fdata  = {16'h0200, 16'h0100};
        fempty = 1'b0;
        vol    = 9'd256;
        en     = 1'b1;
        for (int i = 1; i <= 1001; i++) begin
            if (i <= 1000 && rden_h === 1'b1) nr++;
            if (i <= 1000 && clk_h === 1'b1) hi++;
            if (i >= 2) begin
                if (strobe_h !== prev_r) badal++;
                if (strobe_h === 1'b1) begin
                    ns++;
                    if (clk_h !== 1'b0) badclk++;
                    if (last >= 0 && (i - last) != 12 && (i - last) != 13) badsp++;
                    last = i;
                end
            end
            prev_r = rden_h;
            tick();
        end
        n_cmp++;
        if (nr != 80) begin n_err++; $display("FAIL rate_rden: got %0d pulses expected 80", nr); end
        n_cmp++;
        if (ns != 80) begin n_err++; $display("FAIL rate_strobe: got %0d strobes expected 80", ns); end
        n_cmp++;
        if (badsp != 0) begin n_err++; $display("FAIL rate_spacing: got %0d bad gaps expected 0", badsp); end
        n_cmp++;
        if (badal != 0) begin n_err++; $display("FAIL strobe_align: got %0d misaligned expected 0", badal); end
        n_cmp++;
        if (badclk != 0) begin n_err++; $display("FAIL clk_at_strobe: got %0d high expected 0", badclk); end
        n_cmp++;
        if (hi < 350 || hi > 650) begin n_err++; $display("FAIL clk_duty: got %0d high cycles expected 350..650", hi); end
        // Enable low: no activity, acc parked, output word held.
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rden_h === 1'b1 || strobe_h === 1'b1 || clk_h === 1'b1) nq++;
        end
        n_cmp++;
        if (nq != 0) begin n_err++; $display("FAIL disable_quiet: got %0d active cycles expected 0", nq); end
        n_cmp++;
        if (word_h !== {16'h0200, 16'h0100}) begin
            n_err++;
            $display("FAIL disable_hold: got %h expected 02000100", word_h);
        end
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (first == 0 && rden_h === 1'b1) first = i;
            tick();
        end
        n_cmp++;
        if (first != 13) begin n_err++; $display("FAIL reenable_first: got cycle %0d expected 13", first); end
    endtask

    task automatic test_volume();
        do_reset();
        fdata  = {16'hC000, 16'h4000};
        fempty = 1'b0;
        vol    = 9'd256;
        en     = 1'b1;
        wait_rden("vol256_wait");
        tick();
        tick();
        n_cmp++;
        if (word_h !== {16'hC000, 16'h4000}) begin
            n_err++;
            $display("FAIL vol256: got %h expected c0004000", word_h);
        end
        vol = 9'd128;
        wait_rden("vol128_wait");
        tick();
        n_cmp++;
        if (word_h !== {16'hC000, 16'h4000}) begin
            n_err++;
            $display("FAIL vol128_latency: got %h expected c0004000", word_h);
        end
        tick();
        n_cmp++;
        if (word_h !== {16'hE000, 16'h2000}) begin
            n_err++;
            $display("FAIL vol128: got %h expected e0002000", word_h);
        end
        n_cmp++;
        if (word_z !== {16'hE000, 16'h2000}) begin
            n_err++;
            $display("FAIL vol128_z: got %h expected e0002000", word_z);
        end
        vol = 9'd511;
        wait_rden("vol511_wait");
        tick();
        tick();
        n_cmp++;
        if (word_h !== {16'hC000, 16'h4000}) begin
            n_err++;
            $display("FAIL vol511: got %h expected c0004000", word_h);
        end
    endtask

    task automatic test_underrun();
        bit rd_seen = 0;
        do_reset();
        fdata  = {16'h5678, 16'h1234};
        fempty = 1'b0;
        vol    = 9'd256;
        en     = 1'b1;
        wait_rden("ur_wait");
        tick();
        fempty = 1'b1;
        tick();
        n_cmp++;
        if (word_h !== {16'h5678, 16'h1234} || word_z !== {16'h5678, 16'h1234}) begin
            n_err++;
            $display("FAIL ur_preload: got %h/%h expected 56781234", word_h, word_z);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_strobe("ur_strobe", rd_seen);
            n_cmp++;
            if (cnt_h !== 16'(k) || cnt_z !== 16'(k)) begin
                n_err++;
                $display("FAIL ur_count: got %h/%h expected %h", cnt_h, cnt_z, 16'(k));
            end
            tick();
            n_cmp++;
            if (word_h !== {16'h5678, 16'h1234}) begin
                n_err++;
                $display("FAIL ur_hold: got %h expected 56781234", word_h);
            end
            n_cmp++;
            if (word_z !== 32'h0) begin
                n_err++;
                $display("FAIL ur_zero: got %h expected 0", word_z);
            end
        end
        n_cmp++;
        if (rd_seen) begin n_err++; $display("FAIL ur_no_pop: got fifo_rden high expected never"); end
    endtask

    task automatic test_saturation();
        bit rd_seen = 0;
        logic [15:0] exp;
        force dut_h.ur_cnt_q = 16'hFFFD;
        force dut_z.ur_cnt_q = 16'hFFFD;
        #1;
        release dut_h.ur_cnt_q;
        release dut_z.ur_cnt_q;
        for (int k = 0; k < 3; k++) begin
            exp = (k == 0) ? 16'hFFFE : 16'hFFFF;
            wait_strobe("sat_strobe", rd_seen);
            n_cmp++;
            if (cnt_h !== exp || cnt_z !== exp) begin
                n_err++;
                $display("FAIL sat_count: got %h/%h expected %h", cnt_h, cnt_z, exp);
            end
            tick();
        end
    endtask

    task automatic test_clear_priority();
        bit rd_seen = 0;
        do_reset();
        fempty = 1'b1;
        en     = 1'b1;
        repeat (12) tick();
        uclr = 1'b1;
        tick();
        uclr = 1'b0;
        n_cmp++;
        if (strobe_h !== 1'b1) begin n_err++; $display("FAIL clr_align: got strobe %b expected 1", strobe_h); end
        n_cmp++;
        if (cnt_h !== 16'h0 || cnt_z !== 16'h0) begin
            n_err++;
            $display("FAIL clr_priority: got %h/%h expected 0", cnt_h, cnt_z);
        end
        tick();
        wait_strobe("clr_next", rd_seen);
        n_cmp++;
        if (cnt_h !== 16'h1) begin n_err++; $display("FAIL clr_resume: got %h expected 0001", cnt_h); end
        uclr = 1'b1;
        tick();
        uclr = 1'b0;
        n_cmp++;
        if (cnt_h !== 16'h0) begin n_err++; $display("FAIL clr_plain: got %h expected 0", cnt_h); end
    endtask

    task automatic test_reset_mid();
        int first = 0;
        do_reset();
        fdata  = {16'h2222, 16'h1111};
        fempty = 1'b0;
        vol    = 9'd256;
        en     = 1'b1;
        wait_rden("mid_wait");
        repeat (7) tick();
        n_cmp++;
        if (word_h !== {16'h2222, 16'h1111} || clk_h !== 1'b1) begin
            n_err++;
            $display("FAIL mid_preload: got %h clk %b expected 22221111 clk 1", word_h, clk_h);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rden_h, strobe_h, clk_h} !== 3'b000 || word_h !== 32'h0 || cnt_h !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl %b word %h cnt %h expected all 0",
                     {rden_h, strobe_h, clk_h}, word_h, cnt_h);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (first == 0 && rden_h === 1'b1) first = i;
            tick();
        end
        n_cmp++;
        if (first != 13) begin n_err++; $display("FAIL mid_first_strobe: got cycle %0d expected 13", first); end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_volume();
        test_underrun();
        test_saturation();
        test_clear_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
